ysyx_24110015_isram_resp: RTL
=============================

// Module: ysyx_24110015_isram_resp
// PURPOSE
//  Instruction-memory responder: the memory end of the core's fetch interface. The core
//  side drives a PC as a request; this block accepts it, models a configurable access
//  latency and returns the 32-bit instruction word over a valid/ready handshake.
//  It replaces the ideal combinational inst input in the multi-cycle core; the bench
//  preloads the program image through the load port.
// PARAMETERS
//  BASE     32'h8000_0000  byte address of word 0
//  DEPTH    1024           number of 32-bit words; power of 2, >= 2
//  LATENCY  1              wait cycles between accept and resp_valid, 0..15
// PORTS
//  clk         in   1   single clock, all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   core presents fetch address
//  req_ready   out  1   responder can accept a request this cycle
//  req_addr    in   32  fetch byte address (PC)
//  resp_valid  out  1   resp_data/resp_err valid
//  resp_ready  in   1   core consumes the response this cycle
//  resp_data   out  32  instruction word; 32'h0 when resp_err=1
//  resp_err    out  1   misaligned or out-of-range access
//  load_en     in   1   preload write strobe (bench/loader side)
//  load_idx    in   $clog2(DEPTH)  preload word index
//  load_data   in   32  preload word
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, wait
//    counter 0. Memory contents are NOT cleared by rst.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. req_ready=1 only in IDLE, decoded from state.
//  - IDLE: req_valid&&req_ready at edge T latches req_addr and loads counter=LATENCY;
//    next state WAIT if LATENCY>0, else RESP.
//  - WAIT: counter decrements each cycle; on the edge where counter==1 go to RESP.
//  - The array read, error decode and resp_data/resp_err register load happen on the
//    edge entering RESP. resp_valid rises LATENCY+1 cycles after the accept edge.
//  - RESP: resp_valid=1; resp_data/resp_err held stable until resp_valid&&resp_ready,
//    then IDLE next cycle with resp_valid=0. No accept in the same cycle; max
//    throughput one fetch per LATENCY+2 cycles. One request outstanding at most.
//  - Decode: idx=(addr-BASE)>>2, computed in 32-bit unsigned arithmetic. resp_err=1 if
//    addr[1:0]!=0, addr<BASE, or idx>=DEPTH. On error resp_data=32'h0 and the array
//    is not read. addr=BASE+4*DEPTH-4 is valid; BASE+4*DEPTH is err.
//  - Load port is active in every state. A write and a read to the same index on the
//    same edge return the OLD word (read-before-write). A write after the RESP-entry
//    edge does not alter the held resp_data.
//  - req_addr and req_valid changes while not in IDLE are ignored.
//  - rst in any state, including mid-WAIT and mid-RESP, drops the transaction. The
//    next cycle is IDLE with all outputs at their reset values.
// STRUCTURE
//  - Shared header ysyx_24110015_defs.vh: FSM state encodings (IDLE=2'd0, WAIT=2'd1,
//    RESP=2'd2), RESET_PC=32'h8000_0000 (also used by the PC register).
//  - Sub-module ysyx_24110015_sram_array #(DEPTH,32): one write port, one synchronous
//    read port with a read-enable, read-before-write. The responder holds the FSM,
//    counter, decode and output registers.
// TESTING
//  1 Reset: rst=1 for 2 cycles, then release -> req_ready=1, resp_valid=0, resp_data=0.
//  2 LATENCY=1: preload idx0=32'h00100093; request 32'h8000_0000 at edge T, resp_ready=1
//    -> resp_valid=1 in cycle T+2 with data 32'h00100093 and err=0; IDLE at T+3.
//  3 Backpressure: resp_ready=0 for 5 cycles -> resp_valid and data held constant;
//    req_ready=0 throughout; a single-cycle handshake then returns to IDLE.
//  4 Errors: addr 32'h8000_0002, 32'h7FFF_FFFC and BASE+4*DEPTH -> resp_err=1,
//    data=0. Addr BASE+4*DEPTH-4 -> err=0 with the last preloaded word.
//  5 LATENCY=0 and 15: back-to-back requests -> resp_valid exactly LATENCY+1 cycles
//    after each accept; sequential PCs return the matching words in order.
//  6 rst asserted mid-WAIT and mid-RESP -> IDLE next cycle, resp_valid=0; a fresh fetch
//    still returns the preloaded data (memory intact).

Source files
------------

// File: rtl/ysyx_24110015_isram_resp_pkg.sv
// ysyx_24110015_isram_resp_pkg: shared FSM encodings and reset PC for the fetch responder
//   state_t  : IDLE=0, WAIT=1, RESP=2
//   RESET_PC : byte address of instruction word 0, also used by the PC register
package ysyx_24110015_isram_resp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_24110015_isram_resp_sram.sv
// ysyx_24110015_sram_array: single write port, synchronous read port with read-enable, read-before-write
//   clk          : clock
//   we/widx/wdata: write strobe, word index, word
//   re/ridx      : read enable and word index, rdata updates only when re=1
//   rdata        : registered read word (old contents on same-index write)
module ysyx_24110015_sram_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    ridx,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
        if (re) rdata <= mem[ridx];
    end
endmodule

// File: rtl/ysyx_24110015_isram_resp.sv
// ysyx_24110015_isram_resp: instruction-memory responder with configurable latency and valid/ready response
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr   : fetch request (byte PC), accepted only in IDLE
//   resp_valid/resp_ready          : response handshake
//   resp_data/resp_err             : instruction word, zero on misaligned/out-of-range access
//   load_en/load_idx/load_data     : preload write port, active in every state
// BASE must be word-aligned.
module ysyx_24110015_isram_resp
    import ysyx_24110015_isram_resp_pkg::*;
#(
    parameter logic [31:0] BASE    = RESET_PC,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 1,
    parameter int          AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic          resp_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_idx,
    input  logic [31:0]   load_data
);
    localparam logic [3:0] LAT = LATENCY[3:0];

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] addr_q, addr_n, dec_addr, off, rdata;
    logic        err_q, err_n, err_c, rd_en;

    // With LATENCY=0 the read happens on the accept edge, so decode the live request then.
    assign dec_addr = (state == IDLE) ? req_addr : addr_q;
    assign off      = dec_addr - BASE;
    assign err_c    = (off[1:0] != 2'd0) || (dec_addr < BASE) || ({2'b00, off[31:2]} >= 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        err_n   = err_q;
        rd_en   = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                addr_n  = req_addr;
                cnt_n   = LAT;
                state_n = (LAT == 4'd0) ? RESP : WAIT;
                if (LAT == 4'd0) begin
                    err_n = err_c;
                    rd_en = !err_c;
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = RESP;
                    err_n   = err_c;
                    rd_en   = !err_c;
                end
            end
            RESP: if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The array output register only changes on a RESP-entry edge, so it holds the word through backpressure.
    ysyx_24110015_sram_array #(.DEPTH(DEPTH), .WIDTH(32)) u_sram (
        .clk   (clk),
        .we    (load_en),
        .widx  (load_idx),
        .wdata (load_data),
        .re    (rd_en),
        .ridx  (off[AW+1:2]),
        .rdata (rdata)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_data  = (resp_valid && !err_q) ? rdata : 32'h0;
endmodule
